// File: rtl/vec_popcnt.sv
// vec_popcnt: population count of beat-aligned fingerprint vectors.
// Two-stage pipeline (beat count -> accumulate) with full backpressure.
//
// Ports:
//   clk, rst             clock, synchronous active-high reset
//   up_Vector/VecID      input beat and vector ID (ID taken on beat 0)
//   up_Valid/Last/Ready  input handshake; Last marks end of stream
//   dn_Cnt/VecID         per-vector popcount and its ID
//   dn_Valid/Last/Ready  output handshake; Last marks final vector
//
// Build option: define VEC_POPCNT_TAIL_MASK_EN to zero the padding bits
// of the final beat before counting.
module vec_popcnt #(
  parameter int BUS_WIDTH    = 128,
  parameter int VECTOR_WIDTH = 920,
  parameter int VEC_ID_WIDTH = 8,
  parameter int CNT_WIDTH    = 11
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [BUS_WIDTH-1:0]    up_Vector,
  input  logic [VEC_ID_WIDTH-1:0] up_VecID,
  input  logic                    up_Valid,
  input  logic                    up_Last,
  output logic                    up_Ready,
  output logic [CNT_WIDTH-1:0]    dn_Cnt,
  output logic [VEC_ID_WIDTH-1:0] dn_VecID,
  output logic                    dn_Valid,
  output logic                    dn_Last,
  input  logic                    dn_Ready
);

  localparam int BEATS =
    (VECTOR_WIDTH + BUS_WIDTH - 1) / BUS_WIDTH;
  localparam int BCW = $clog2(BUS_WIDTH + 1);
  localparam int IDXW =
    (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [IDXW-1:0] LAST_IDX =
    IDXW'(BEATS - 1);

`ifdef VEC_POPCNT_TAIL_MASK_EN
  localparam int TAIL_BITS =
    VECTOR_WIDTH - (BEATS - 1) * BUS_WIDTH;
  localparam logic [BUS_WIDTH-1:0] ONES = '1;
  localparam logic [BUS_WIDTH-1:0] TAIL_MASK =
    ONES >> (BUS_WIDTH - TAIL_BITS);
`endif

  typedef struct packed {
    logic                    vld;
    logic                    first;
    logic                    fin;
    logic                    last;
    logic [VEC_ID_WIDTH-1:0] id;
    logic [BCW-1:0]          cnt;
  } s1_t;

  function automatic logic [BCW-1:0] popcnt(
    input logic [BUS_WIDTH-1:0] v
  );
    logic [BCW-1:0] s;
    s = '0;
    for (int i = 0; i < BUS_WIDTH; i++) begin
      s = s + BCW'(v[i]);
    end
    return s;
  endfunction

  logic [IDXW-1:0]         idx_q, idx_d;
  logic [VEC_ID_WIDTH-1:0] vid_q, vid_d;
  s1_t                     s1_q, s1_d;
  logic [CNT_WIDTH-1:0]    acc_q, acc_d;
  logic [CNT_WIDTH-1:0]    cnt_q, cnt_d;
  logic [VEC_ID_WIDTH-1:0] oid_q, oid_d;
  logic                    olast_q, olast_d;
  logic                    ovld_q, ovld_d;

  logic                    stall;
  logic                    accept;
  logic                    is_first;
  logic                    is_final;
  logic [BUS_WIDTH-1:0]    beat_m;
  logic [BCW-1:0]          beat_cnt;
  logic [CNT_WIDTH-1:0]    cnt_ext;
  logic [CNT_WIDTH-1:0]    vec_sum;

  assign stall    = ovld_q && !dn_Ready;
  assign up_Ready = !rst && !stall;
  assign accept   = up_Valid && up_Ready;
  assign is_first = (idx_q == '0);
  // Early up_Last closes the vector on any beat.
  assign is_final = (idx_q == LAST_IDX) || up_Last;

  always_comb begin
    beat_m = up_Vector;
`ifdef VEC_POPCNT_TAIL_MASK_EN
    if (idx_q == LAST_IDX) begin
      beat_m = up_Vector & TAIL_MASK;
    end
`endif
  end

  assign beat_cnt = popcnt(beat_m);
  assign cnt_ext  = CNT_WIDTH'(s1_q.cnt);
  assign vec_sum  =
    (s1_q.first ? '0 : acc_q) + cnt_ext;

  // Beat index and captured ID.
  always_comb begin
    idx_d = idx_q;
    vid_d = vid_q;
    unique case (1'b1)
      (accept && is_final):  idx_d = '0;
      (accept && !is_final): idx_d = idx_q + IDXW'(1);
      default:               idx_d = idx_q;
    endcase
    if (accept && is_first) begin
      vid_d = up_VecID;
    end
  end

  // Stage 1: per-beat count and flags.
  always_comb begin
    s1_d = s1_q;
    if (!stall) begin
      s1_d.vld = accept;
      if (accept) begin
        s1_d.first = is_first;
        s1_d.fin   = is_final;
        s1_d.last  = up_Last;
        s1_d.id    = is_first ? up_VecID : vid_q;
        s1_d.cnt   = beat_cnt;
      end
    end
  end

  // Stage 2: accumulator and output register.
  always_comb begin
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    oid_d   = oid_q;
    olast_d = olast_q;
    ovld_d  = ovld_q;
    if (!stall) begin
      if (s1_q.vld) begin
        acc_d = s1_q.first ? cnt_ext : acc_q + cnt_ext;
      end
      // Not stalled: any pending result is consumed this edge.
      unique case (1'b1)
        (s1_q.vld && s1_q.fin): begin
          cnt_d   = vec_sum;
          oid_d   = s1_q.id;
          olast_d = s1_q.last;
          ovld_d  = 1'b1;
        end
        default: ovld_d = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      idx_q   <= '0;
      vid_q   <= '0;
      s1_q    <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      oid_q   <= '0;
      olast_q <= 1'b0;
      ovld_q  <= 1'b0;
    end else begin
      idx_q   <= idx_d;
      vid_q   <= vid_d;
      s1_q    <= s1_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      oid_q   <= oid_d;
      olast_q <= olast_d;
      ovld_q  <= ovld_d;
    end
  end

  assign dn_Cnt   = cnt_q;
  assign dn_VecID = oid_q;
  assign dn_Last  = olast_q;
  assign dn_Valid = ovld_q;

endmodule

// File: tb/tb_vec_popcnt.sv
// tb_vec_popcnt: self-checking bench for vec_popcnt.
// Scenario tasks compare against a popcount reference model.
module tb_vec_popcnt;

  localparam int BW    = 128;
  localparam int VW    = 920;
  localparam int IW    = 8;
  localparam int CW    = 11;
  localparam int BEATS = 8;
  localparam int TAIL  = 24;
  localparam int NR    = 6;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [BW-1:0] up_Vector = '0;
  logic [IW-1:0] up_VecID = '0;
  logic          up_Valid = 1'b0;
  logic          up_Last = 1'b0;
  logic          up_Ready;
  logic [CW-1:0] dn_Cnt;
  logic [IW-1:0] dn_VecID;
  logic          dn_Valid;
  logic          dn_Last;
  logic          dn_Ready = 1'b1;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  bit done = 0;

  logic [BW-1:0] vb [BEATS];
  logic [BW-1:0] rdata [NR][BEATS];
  int            exp_c [NR];
  logic [IW-1:0] exp_id [NR];

  vec_popcnt #(
    .BUS_WIDTH(BW), .VECTOR_WIDTH(VW),
    .VEC_ID_WIDTH(IW), .CNT_WIDTH(CW)
  ) dut (
    .clk(clk), .rst(rst),
    .up_Vector(up_Vector), .up_VecID(up_VecID),
    .up_Valid(up_Valid), .up_Last(up_Last),
    .up_Ready(up_Ready),
    .dn_Cnt(dn_Cnt), .dn_VecID(dn_VecID),
    .dn_Valid(dn_Valid), .dn_Last(dn_Last),
    .dn_Ready(dn_Ready)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference: ones in the first nb beats of vb.
  function automatic int model_cnt(int nb);
    int s;
    logic [BW-1:0] b;
    s = 0;
    for (int k = 0; k < nb; k++) begin
      b = vb[k];
`ifdef VEC_POPCNT_TAIL_MASK_EN
      if (k == BEATS - 1)
        for (int j = TAIL; j < BW; j++) b[j] = 1'b0;
`endif
      s += $countones(b);
    end
    return s;
  endfunction

  function automatic logic [BW-1:0] rnd_beat();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  function automatic logic [BW-1:0] low_ones(int n);
    logic [BW-1:0] one;
    one = 1;
    if (n >= BW) return '1;
    return (one << n) - one;
  endfunction

  task automatic align();
    @(posedge clk); #1;
  endtask

  // Called at posedge+1; returns at posedge+1 after acceptance.
  task automatic send_beat(input logic [BW-1:0] d,
                           input logic [IW-1:0] id,
                           input logic lst, output bit ok);
    bit r;
    up_Vector = d; up_VecID = id;
    up_Last = lst; up_Valid = 1'b1;
    ok = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      r = up_Ready;
      @(posedge clk); #1;
      if (r) begin ok = 1; break; end
    end
    up_Valid = 1'b0; up_Last = 1'b0;
  endtask

  task automatic get_result(output logic [CW-1:0] c,
                            output logic [IW-1:0] id,
                            output logic l, output int t,
                            output bit ok);
    ok = 0; c = '0; id = '0; l = 1'b0; t = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (dn_Valid && dn_Ready) begin
        c = dn_Cnt; id = dn_VecID; l = dn_Last;
        t = cyc; ok = 1; break;
      end
    end
  endtask

  task automatic send_vec(input int nb, input logic [IW-1:0] id,
                          input logic last_on_end);
    bit ok;
    for (int k = 0; k < nb; k++) begin
      send_beat(vb[k], (k == 0) ? id : IW'($urandom),
                last_on_end && (k == nb - 1), ok);
      checks++;
      if (!ok) begin
        failures++;
        $display("FAIL send_timeout beat=%0d", k);
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; up_Valid = 1'b0; dn_Ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if (up_Ready !== 1'b0) begin failures++;
      $display("FAIL rst_up_ready got=%b exp=0", up_Ready); end
    checks++;
    if (dn_Valid !== 1'b0) begin failures++;
      $display("FAIL rst_dn_valid got=%b exp=0", dn_Valid); end
    checks++;
    if (dn_Cnt !== '0 || dn_VecID !== '0 || dn_Last !== 1'b0)
    begin failures++;
      $display("FAIL rst_dn_data cnt=%0d id=%0d last=%b exp=0",
               dn_Cnt, dn_VecID, dn_Last); end
    align();
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (up_Ready !== 1'b1) begin failures++;
      $display("FAIL rst_release_ready got=%b exp=1", up_Ready); end
    align();
  endtask

  task automatic test_all_ones();
    for (int k = 0; k < BEATS; k++)
      vb[k] = low_ones((k == BEATS - 1) ? TAIL : BW);
    send_vec(BEATS, 8'h05, 1'b1);
    @(negedge clk);
    checks++;
    if (dn_Valid !== 1'b0) begin failures++;
      $display("FAIL ones_early_valid got=%b exp=0", dn_Valid); end
    @(negedge clk);
    checks++;
    if (dn_Valid !== 1'b1) begin failures++;
      $display("FAIL ones_latency_valid got=%b exp=1", dn_Valid); end
    checks++;
    if (dn_Cnt !== CW'(920)) begin failures++;
      $display("FAIL ones_cnt got=%0d exp=920", dn_Cnt); end
    checks++;
    if (dn_VecID !== 8'h05 || dn_Last !== 1'b1) begin failures++;
      $display("FAIL ones_id_last id=%h last=%b exp=05/1",
               dn_VecID, dn_Last); end
    align();
  endtask

  task automatic test_tail_pad();
    logic [CW-1:0] c; logic [IW-1:0] id; logic l;
    int t, exp; bit ok;
    for (int k = 0; k < BEATS; k++) vb[k] = '0;
    vb[BEATS-1] = ~low_ones(TAIL);
`ifdef VEC_POPCNT_TAIL_MASK_EN
    exp = 0;
`else
    exp = 104;
`endif
    send_vec(BEATS, 8'h44, 1'b0);
    get_result(c, id, l, t, ok);
    checks++;
    if (!ok || c !== CW'(exp) || id !== 8'h44) begin failures++;
      $display("FAIL tail_pad ok=%0d cnt=%0d id=%h exp=%0d/44",
               ok, c, id, exp); end
    align();
  endtask

  task automatic test_back_to_back();
    int tt [3];
    fork
      begin
        for (int v = 0; v < 3; v++) begin
          for (int k = 0; k < BEATS; k++) vb[k] = low_ones(k + 1);
          send_vec(BEATS, IW'(v + 1), 1'b0);
        end
      end
      begin
        logic [CW-1:0] c; logic [IW-1:0] id; logic l; bit ok;
        for (int r = 0; r < 3; r++) begin
          get_result(c, id, l, tt[r], ok);
          checks++;
          if (!ok || c !== CW'(36) || id !== IW'(r + 1) || l !== 1'b0)
          begin failures++;
            $display("FAIL b2b_result r=%0d ok=%0d cnt=%0d id=%0d last=%b exp=36/%0d/0",
                     r, ok, c, id, l, r + 1); end
        end
      end
    join
    for (int r = 1; r < 3; r++) begin
      checks++;
      if (tt[r] - tt[r-1] != BEATS) begin failures++;
        $display("FAIL b2b_spacing r=%0d got=%0d exp=%0d",
                 r, tt[r] - tt[r-1], BEATS); end
    end
    align();
  endtask

  task automatic test_stall();
    int expa, expb;
    for (int k = 0; k < BEATS; k++) vb[k] = rnd_beat();
    expa = model_cnt(BEATS);
    dn_Ready = 1'b0;
    send_vec(BEATS, 8'h61, 1'b0);
    for (int k = 0; k < BEATS; k++) vb[k] = rnd_beat();
    expb = model_cnt(BEATS);
    fork
      send_vec(BEATS, 8'h62, 1'b0);
      begin
        logic [CW-1:0] c; logic [IW-1:0] id; logic l;
        int t; bit ok; bit bad;
        ok = 0;
        for (int i = 0; i < 50; i++) begin
          @(negedge clk);
          if (dn_Valid) begin ok = 1; break; end
        end
        checks++;
        if (!ok) begin failures++;
          $display("FAIL stall_no_valid got=0 exp=1"); end
        bad = 0;
        for (int i = 0; i < 10; i++) begin
          if (up_Ready !== 1'b0 || dn_Valid !== 1'b1 ||
              dn_Cnt !== CW'(expa) || dn_VecID !== 8'h61) bad = 1;
          if (i < 9) @(negedge clk);
        end
        checks++;
        if (bad) begin failures++;
          $display("FAIL stall_hold ready=%b cnt=%0d id=%h exp=0/%0d/61",
                   up_Ready, dn_Cnt, dn_VecID, expa); end
        align();
        dn_Ready = 1'b1;
        get_result(c, id, l, t, ok);
        checks++;
        if (!ok || c !== CW'(expa) || id !== 8'h61) begin failures++;
          $display("FAIL stall_first ok=%0d cnt=%0d id=%h exp=%0d/61",
                   ok, c, id, expa); end
        get_result(c, id, l, t, ok);
        checks++;
        if (!ok || c !== CW'(expb) || id !== 8'h62) begin failures++;
          $display("FAIL stall_next ok=%0d cnt=%0d id=%h exp=%0d/62",
                   ok, c, id, expb); end
      end
    join
    align();
  endtask

  task automatic test_early_last();
    logic [CW-1:0] c; logic [IW-1:0] id; logic l;
    int t, exp; bit ok;
    for (int k = 0; k < BEATS; k++) vb[k] = '1;
    send_vec(3, 8'h3C, 1'b1);
    get_result(c, id, l, t, ok);
    checks++;
    if (!ok || c !== CW'(384) || id !== 8'h3C || l !== 1'b1)
    begin failures++;
      $display("FAIL early_last ok=%0d cnt=%0d id=%h last=%b exp=384/3c/1",
               ok, c, id, l); end
    align();
    for (int k = 0; k < BEATS; k++) vb[k] = rnd_beat();
    exp = model_cnt(BEATS);
    send_vec(BEATS, 8'hA7, 1'b0);
    get_result(c, id, l, t, ok);
    checks++;
    if (!ok || c !== CW'(exp) || id !== 8'hA7 || l !== 1'b0)
    begin failures++;
      $display("FAIL after_early ok=%0d cnt=%0d id=%h last=%b exp=%0d/a7/0",
               ok, c, id, l, exp); end
    align();
  endtask

  task automatic test_reset_mid();
    logic [CW-1:0] c; logic [IW-1:0] id; logic l;
    int t; bit ok;
    for (int k = 0; k < BEATS; k++) vb[k] = '1;
    send_vec(5, 8'h11, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (up_Ready !== 1'b0) begin failures++;
      $display("FAIL midrst_ready got=%b exp=0", up_Ready); end
    align();
    rst = 1'b0;
    for (int k = 0; k < BEATS; k++)
      vb[k] = low_ones((k == BEATS - 1) ? TAIL : BW);
    send_vec(BEATS, 8'h22, 1'b0);
    get_result(c, id, l, t, ok);
    checks++;
    if (!ok || c !== CW'(920) || id !== 8'h22) begin failures++;
      $display("FAIL midrst_next ok=%0d cnt=%0d id=%h exp=920/22",
               ok, c, id); end
    align();
  endtask

  task automatic test_random();
    for (int v = 0; v < NR; v++) begin
      for (int k = 0; k < BEATS; k++) begin
        rdata[v][k] = rnd_beat();
        vb[k] = rdata[v][k];
      end
      exp_c[v] = model_cnt(BEATS);
      exp_id[v] = IW'($urandom);
    end
    done = 0;
    fork
      begin
        bit ok;
        for (int v = 0; v < NR; v++)
          for (int k = 0; k < BEATS; k++) begin
            repeat ($urandom_range(0, 2)) align();
            send_beat(rdata[v][k],
                      (k == 0) ? exp_id[v] : IW'($urandom),
                      (v == NR - 1) && (k == BEATS - 1), ok);
            checks++;
            if (!ok) begin failures++;
              $display("FAIL rnd_send v=%0d k=%0d", v, k); end
          end
      end
      begin
        logic [CW-1:0] c; logic [IW-1:0] id; logic l;
        int t; bit ok;
        for (int v = 0; v < NR; v++) begin
          get_result(c, id, l, t, ok);
          checks++;
          if (!ok || c !== CW'(exp_c[v]) || id !== exp_id[v] ||
              l !== (v == NR - 1)) begin failures++;
            $display("FAIL rnd_result v=%0d ok=%0d cnt=%0d id=%h last=%b exp=%0d/%h/%0d",
                     v, ok, c, id, l, exp_c[v], exp_id[v],
                     (v == NR - 1)); end
        end
        done = 1;
      end
      begin
        while (!done) begin
          align();
          dn_Ready = ($urandom_range(0, 3) != 0);
        end
        dn_Ready = 1'b1;
      end
    join
    align();
  endtask

  initial begin
    test_reset();
    test_all_ones();
    test_tail_pad();
    test_back_to_back();
    test_stall();
    test_early_last();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
